memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- ADDR_WIDTH, 9, word-address width; depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 3, cycles from request acceptance to Done; legal range 1..15.
REQ-002 Ports, one per line: name, direction, width, meaning:
- Clock, input, 1, single clock; all state on rising edge.
- Clear, input, 1, asynchronous active-low reset.
- Read, input, 1, read request level from datapath (MAR addresses, MDR receives).
- Write, input, 1, write request level from datapath (MDR supplies data).
- Address, input, ADDR_WIDTH, word address (MAR low bits).
- Data_in, input, 32, write data (MDR contents).
- Mdatain, output, 32, read data presented to MDR Mdatain.
- Done, output, 1, one-cycle completion strobe.
- Busy, output, 1, transaction in flight.
- Collision, output, 1, sticky flag: Read and Write requested together.

Function
REQ-003 FSM states IDLE, WAIT, RESP; encoding at implementer's discretion.
REQ-004 IDLE: at a rising edge with Read or Write high, SHALL capture Address, Data_in and operation type, load latency counter with LATENCY-1, enter WAIT (or RESP directly when LATENCY=1).
REQ-005 Read and Write both high in IDLE: SHALL perform Read only, set Collision; Collision clears only on reset.
REQ-006 WAIT: counter decrements once per cycle; at counter 1 the next state SHALL be RESP.
REQ-007 RESP: Done high for exactly one cycle; next state IDLE; request sampled at edge N yields Done high in cycle following edge N+LATENCY-1 (Done observed at edge N+LATENCY).
REQ-008 Read completion: Mdatain SHALL update to memory[captured address] in the same cycle Done is high and SHALL hold until the next read completes.
REQ-009 Write completion: memory[captured address] SHALL be written with captured Data_in on the edge ending the RESP cycle; Mdatain unchanged by writes.
REQ-010 Busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-011 Requests while Busy SHALL be ignored (not queued); Address/Data_in changes while Busy SHALL not affect the in-flight transaction.
REQ-012 Request held high across RESP SHALL be accepted again at the first IDLE edge (back-to-back: one idle cycle between Done pulses).
REQ-013 Read after write to same address SHALL return the written data.
REQ-014 Memory is a synchronous-write word array; no byte enables; address wraps naturally within ADDR_WIDTH bits.

Reset
REQ-015 Clear low SHALL asynchronously force: state IDLE, counter 0, Done 0, Busy 0, Mdatain 32'h0, Collision 0.
REQ-016 Memory array contents SHALL NOT be cleared by reset.
REQ-017 Reset mid-transaction SHALL abandon it: no Done pulse, pending write not committed.
REQ-018 After Clear deasserts, first request accepted at the first rising edge with Clear high.

Verification
REQ-019 Write 32'hDEADBEEF to address 5 (LATENCY=3), then read address 5 -> Done once per op, 3 cycles after each accept; Mdatain = 32'hDEADBEEF with second Done.
REQ-020 Read held high continuously at address 7 (preloaded 32'h12345678) -> Done pulses every LATENCY+1 cycles, Mdatain steady 32'h12345678, Busy low exactly one cycle between.
REQ-021 Read and Write high together at address 2 holding 32'h0000_00AA, Data_in 32'hFFFF_FFFF -> read performed, Mdatain 32'h000000AA, address 2 unchanged, Collision = 1 until reset.
REQ-022 Write 32'h0BADF00D to address 9, Clear low one cycle after accept -> Done never asserts, Busy 0 immediately, later read of address 9 returns prior value.
REQ-023 Change Address from 3 to 4 during WAIT of a read of 3 -> Mdatain = memory[3]; second read during Busy ignored (no extra Done).
REQ-024 LATENCY=1 build: read accepted at edge N -> Done observed at edge N+1, Busy high exactly one cycle.

Source files
------------

// File: rtl/memory_responder.sv
// Fixed-latency word memory responder for a MAR/MDR datapath.
// State | meaning: IDLE = waiting for a request; WAIT = latency countdown; RESP = Done strobe, write commit.
module memory_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 3
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           Data_in,
  output logic [31:0]           Mdatain,
  output logic                  Done,
  output logic                  Busy,
  output logic                  Collision
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  is_write_q;
  logic [31:0]           mdatain_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  collision_q;
  logic [31:0]           mem_q [DEPTH];

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      data_q      <= 32'h0;
      is_write_q  <= 1'b0;
      mdatain_q   <= 32'h0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Read || Write) begin
            addr_q     <= Address;
            data_q     <= Data_in;
            // A simultaneous read/write request is served as a read only.
            is_write_q <= Write && !Read;
            cnt_q      <= LOAD;
            busy_q     <= 1'b1;
            if (Read && Write) collision_q <= 1'b1;
            if (LATENCY == 1) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              if (Read) mdatain_q <= mem_q[Address];
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            if (!is_write_q) mdatain_q <= mem_q[addr_q];
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; an abandoned write never reaches RESP so is never committed.
  always_ff @(posedge Clock) begin
    if (state_q == RESP && is_write_q) mem_q[addr_q] <= data_q;
  end

  assign Mdatain   = mdatain_q;
  assign Done      = done_q;
  assign Busy      = busy_q;
  assign Collision = collision_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: LATENCY=3 and LATENCY=1 instances.
module tb_memory_responder;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic        rd3 = 1'b0, wr3 = 1'b0;
  logic [8:0]  addr3 = '0;
  logic [31:0] din3 = '0;
  logic [31:0] mdat3;
  logic        done3, busy3, coll3;
  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [8:0]  addr1 = '0;
  logic [31:0] din1 = '0;
  logic [31:0] mdat1;
  logic        done1, busy1, coll1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  memory_responder #(.ADDR_WIDTH(9), .LATENCY(3)) u_dut3 (
    .Clock(Clock), .Clear(Clear), .Read(rd3), .Write(wr3), .Address(addr3),
    .Data_in(din3), .Mdatain(mdat3), .Done(done3), .Busy(busy3), .Collision(coll3)
  );

  memory_responder #(.ADDR_WIDTH(9), .LATENCY(1)) u_dut1 (
    .Clock(Clock), .Clear(Clear), .Read(rd1), .Write(wr1), .Address(addr1),
    .Data_in(din1), .Mdatain(mdat1), .Done(done1), .Busy(busy1), .Collision(coll1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One LATENCY=3 transaction; k counts edges after the accept edge (k=0 is the accept edge).
  task automatic op3(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d,
                     output int done_k, output int done_cnt);
    @(negedge Clock);
    rd3 = rd; wr3 = wr; addr3 = a; din3 = d;
    @(posedge Clock); #1;
    rd3 = 1'b0; wr3 = 1'b0;
    done_k = -1; done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(posedge Clock); #1; end
      if (done3) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
    end
  endtask

  initial begin
    int dk, dc;

    #2 Clear = 1'b0;
    #20;
    check("rst_done", {31'b0, done3}, 32'h0);
    check("rst_busy", {31'b0, busy3}, 32'h0);
    check("rst_mdat", mdat3, 32'h0);
    check("rst_coll", {31'b0, coll3}, 32'h0);
    @(negedge Clock);
    Clear = 1'b1;

    op3(1'b0, 1'b1, 9'd5, 32'hDEADBEEF, dk, dc);
    check("wr5_lat", dk, 32'd2);
    check("wr5_cnt", dc, 32'd1);
    check("wr5_mdat_unchanged", mdat3, 32'h0);
    op3(1'b1, 1'b0, 9'd5, 32'h0, dk, dc);
    check("rd5_lat", dk, 32'd2);
    check("rd5_cnt", dc, 32'd1);
    check("rd5_data", mdat3, 32'hDEADBEEF);

    op3(1'b0, 1'b1, 9'd7, 32'h12345678, dk, dc);
    op3(1'b0, 1'b1, 9'd2, 32'h000000AA, dk, dc);
    op3(1'b0, 1'b1, 9'd9, 32'h11111111, dk, dc);
    op3(1'b0, 1'b1, 9'd3, 32'h33333333, dk, dc);
    op3(1'b0, 1'b1, 9'd4, 32'h44444444, dk, dc);

    // Read held high: accept at i=0, Done at i%4==2, Busy low at i%4==3.
    @(negedge Clock);
    rd3 = 1'b1; addr3 = 9'd7;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clock); #1;
      check($sformatf("hold_done_%0d", i), {31'b0, done3}, {31'b0, (i % 4) == 2});
      check($sformatf("hold_busy_%0d", i), {31'b0, busy3}, {31'b0, (i % 4) != 3});
      if (i >= 2) check($sformatf("hold_mdat_%0d", i), mdat3, 32'h12345678);
    end
    rd3 = 1'b0;
    repeat (2) @(posedge Clock);

    op3(1'b1, 1'b1, 9'd2, 32'hFFFFFFFF, dk, dc);
    check("coll_lat", dk, 32'd2);
    check("coll_mdat", mdat3, 32'h000000AA);
    check("coll_flag", {31'b0, coll3}, 32'h1);
    op3(1'b1, 1'b0, 9'd2, 32'h0, dk, dc);
    check("coll_addr2_kept", mdat3, 32'h000000AA);
    check("coll_sticky", {31'b0, coll3}, 32'h1);

    // Reset one cycle after accepting a write: abandoned, never committed.
    @(negedge Clock);
    wr3 = 1'b1; addr3 = 9'd9; din3 = 32'h0BADF00D;
    @(posedge Clock); #1;
    wr3 = 1'b0;
    check("abort_busy_pre", {31'b0, busy3}, 32'h1);
    @(posedge Clock); #1;
    Clear = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy3}, 32'h0);
    check("abort_coll_clr", {31'b0, coll3}, 32'h0);
    check("abort_mdat_clr", mdat3, 32'h0);
    dc = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clock); #1;
      if (done3) dc++;
      if (k == 1) Clear = 1'b1;
    end
    check("abort_no_done", dc, 32'd0);
    op3(1'b1, 1'b0, 9'd9, 32'h0, dk, dc);
    check("abort_rd9", mdat3, 32'h11111111);

    // Address change and second read while busy.
    @(negedge Clock);
    rd3 = 1'b1; addr3 = 9'd3;
    @(posedge Clock); #1;
    addr3 = 9'd4;
    dk = -1; dc = 0;
    for (int k = 1; k < 9; k++) begin
      @(posedge Clock); #1;
      if (k == 1) rd3 = 1'b0;
      if (done3) begin
        dc++;
        if (dk < 0) dk = k;
      end
    end
    check("busy_ign_lat", dk, 32'd2);
    check("busy_ign_cnt", dc, 32'd1);
    check("busy_ign_mdat", mdat3, 32'h33333333);

    // LATENCY=1 instance.
    @(negedge Clock);
    wr1 = 1'b1; addr1 = 9'd1; din1 = 32'hCAFEF00D;
    @(posedge Clock); #1;
    wr1 = 1'b0;
    check("l1_wr_done", {31'b0, done1}, 32'h1);
    check("l1_wr_mdat", mdat1, 32'h0);
    @(posedge Clock); #1;
    check("l1_wr_busy_off", {31'b0, busy1}, 32'h0);
    @(negedge Clock);
    rd1 = 1'b1; addr1 = 9'd1;
    @(posedge Clock); #1;
    rd1 = 1'b0;
    check("l1_rd_done", {31'b0, done1}, 32'h1);
    check("l1_rd_busy", {31'b0, busy1}, 32'h1);
    check("l1_rd_data", mdat1, 32'hCAFEF00D);
    @(posedge Clock); #1;
    check("l1_rd_done_off", {31'b0, done1}, 32'h0);
    check("l1_rd_busy_off", {31'b0, busy1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
